mux8_rr_scheduler: RTL and testbench
====================================

// Module: mux8_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing the 8:1 single-bit mux (inputs A..H, selects sel1..sel3)
//  between 8 requesters. Registered Moore FSM: grants one requester at a time for a fixed
//  time slot and drives the mux select lines. Sits directly in front of mux8x1;
//  sel1/sel2/sel3 connect port-for-port. Requester i owns mux input i (0=A ... 7=H).
// PARAMETERS
//  SLOT_LEN   4     cycles per grant slot; legal 1..255 (8-bit down-counter)
//  IDLE_SEL   3'd0  {sel1,sel2,sel3} value driven while no grant is active
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous, active-high reset
//  req        in   8  request vector; req[i] = requester i wants the mux
//  lock       in   1  extend current slot (present only with MUX_SCHED_LOCK_EN)
//  sel1       out  1  mux select MSB (registered)
//  sel2       out  1  mux select mid bit (registered)
//  sel3       out  1  mux select LSB (registered)
//  gnt        out  8  one-hot grant; all-zero when idle (registered)
//  gnt_valid  out  1  high while a grant is active (registered)
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state=IDLE, gnt=8'h00, gnt_valid=0, {sel1,sel2,sel3}=IDLE_SEL,
//    cnt=0, last_ptr=7 (so requester 0 wins first). Reset overrides everything, mid-slot included.
//  - All outputs are registered. Latency: req sampled at edge N gives grant outputs valid after edge N.
//  - Pick rule: first i with req[i]=1, scanning last_ptr+1, +2, ... mod 8 (wraps 7->0).
//    last_ptr = index of the most recent grant.
//  - IDLE: req==0 -> stay in IDLE, outputs unchanged. req!=0 -> GRANT winner w: gnt=1<<w,
//    {sel1,sel2,sel3}=w, gnt_valid=1, cnt=SLOT_LEN-1, last_ptr=w.
//  - GRANT (owner c), evaluated each edge:
//    a) req[c]=0 -> early release: re-arbitrate over req with bit c masked.
//    b) req[c]=1 and cnt!=0 -> hold; cnt=cnt-1.
//    c) req[c]=1 and cnt==0 -> slot expiry: re-arbitrate from c+1. If c is the only
//       requester, c is re-granted (cnt reloads).
//    d) Re-arbitration with a winner -> new grant as in IDLE, same edge, no bubble cycle.
//       No winner -> IDLE, gnt=0, gnt_valid=0, sel=IDLE_SEL.
//  - Slot length is exactly SLOT_LEN cycles of gnt_valid for an uninterrupted owner.
//    SLOT_LEN=1 gives a new arbitration every cycle.
//  - New requests arriving mid-slot never pre-empt the owner; they wait for release or expiry.
//  - Invariants: gnt is zero or one-hot; gnt_valid == |gnt; sel always equals the index
//    of the set gnt bit while gnt_valid=1.
// CONFIGURATION
//  MUX_SCHED_LOCK_EN defined: lock port exists. In GRANT with req[c]=1 and lock=1,
//    cnt freezes and expiry is suppressed, so the owner keeps the mux indefinitely.
//    Early release on req[c]=0 still applies. lock is ignored in IDLE.
//  MUX_SCHED_LOCK_EN undefined: no lock port; slots always expire per rule c.
// TESTING
//  1 rst=1 for 2 cycles, req=8'hFF -> gnt=0, gnt_valid=0, sel=IDLE_SEL throughout reset.
//  2 After reset, req=8'hFF, SLOT_LEN=4 -> grants 0,1,...,7,0 in order, 4 cycles each.
//    sel steps 000->001->...->111->000. No idle gap between slots.
//  3 req=8'h01 held -> gnt=8'h01 continuously (re-granted at each expiry), sel=000, gnt_valid stays 1.
//  4 Owner 2 drops req[2] after 1 cycle with req=8'h81 -> next edge gnt=8'h80, sel=111.
//    Then req=0 -> IDLE, gnt=0, sel=IDLE_SEL.
//  5 rst pulsed mid-slot while gnt=8'h10 -> next edge all outputs at reset values.
//    Next grant after reset starts from requester 0.
//  6 (MUX_SCHED_LOCK_EN) owner 5, lock=1 for 20 cycles with req=8'hFF -> gnt=8'h20 for all 20 cycles.
//    After lock=0, gnt moves to 8'h40 after the remaining slot cycles.

Source files
------------

// File: rtl/mux8_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mux8_rr_scheduler
//
// Purpose:
//   A round-robin scheduler that lets 8 requesters share one 8:1 single-bit
//   mux (inputs A..H, selects sel1..sel3). Requester i owns mux input i
//   (0=A ... 7=H). The block is a registered Moore FSM. It grants one
//   requester at a time for a fixed slot of SLOT_LEN cycles and drives the
//   mux select lines from the same register as the grant.
//
// Parameters:
//   SLOT_LEN  cycles per grant slot (1..255)
//   IDLE_SEL  {sel1,sel2,sel3} value driven while no grant is active
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous, active-high reset
//   req        in   8  request vector; req[i] = requester i wants the mux
//   lock       in   1  extend the current slot (only with MUX_SCHED_LOCK_EN)
//   sel1       out  1  mux select MSB (registered)
//   sel2       out  1  mux select mid bit (registered)
//   sel3       out  1  mux select LSB (registered)
//   gnt        out  8  one-hot grant; all-zero when idle (registered)
//   gnt_valid  out  1  high while a grant is active (registered)
//
// Configuration macro:
//   MUX_SCHED_LOCK_EN  when defined, adds the lock input. While the owner
//                      keeps requesting, lock=1 freezes the slot counter and
//                      suppresses expiry.
// ---------------------------------------------------------------------------
module mux8_rr_scheduler #(
    parameter int unsigned SLOT_LEN = 4,
    parameter logic [2:0]  IDLE_SEL = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
`ifdef MUX_SCHED_LOCK_EN
    input  logic       lock,
`endif
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    output logic [7:0] gnt,
    output logic       gnt_valid
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] last_ptr_q, last_ptr_d;

    logic       do_arb;
    logic [7:0] arb_req;
    logic [3:0] pick_res;
    logic       hold_lock;

    // Round-robin pick. The function returns {found, index} for the first set
    // bit, scanning from ptr+1 upward with wrap-around. ptr itself is visited
    // last. The loop runs from the farthest candidate to the nearest, so the
    // nearest set bit is the one that remains in res.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 8; k >= 1; k--) begin
            idx = ptr + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

`ifdef MUX_SCHED_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    // During GRANT, last_ptr_q is also the current owner index. So one
    // pointer serves both as the round-robin start point and as the owner.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        gnt_valid_d = gnt_valid_q;
        cnt_d       = cnt_q;
        last_ptr_d  = last_ptr_q;
        do_arb      = 1'b0;
        arb_req     = 8'd0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    do_arb  = 1'b1;
                    arb_req = req;
                end
            end
            ST_GRANT: begin
                if (!req[last_ptr_q]) begin
                    // Early release: the owner may not win again.
                    do_arb  = 1'b1;
                    arb_req = req & ~(8'd1 << last_ptr_q);
                end else if (hold_lock) begin
                    cnt_d = cnt_q;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Expiry: the owner stays eligible, but only as the last candidate.
                    do_arb  = 1'b1;
                    arb_req = req;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pick_res = rr_pick(arb_req, last_ptr_q);

        if (do_arb) begin
            if (pick_res[3]) begin
                state_d     = ST_GRANT;
                gnt_d       = 8'd1 << pick_res[2:0];
                sel_d       = pick_res[2:0];
                gnt_valid_d = 1'b1;
                cnt_d       = 8'(SLOT_LEN - 1);
                last_ptr_d  = pick_res[2:0];
            end else begin
                state_d     = ST_IDLE;
                gnt_d       = 8'd0;
                sel_d       = IDLE_SEL;
                gnt_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 8'd0;
            sel_q       <= IDLE_SEL;
            gnt_valid_q <= 1'b0;
            cnt_q       <= 8'd0;
            last_ptr_q  <= 3'd7;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            gnt_valid_q <= gnt_valid_d;
            cnt_q       <= cnt_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

    assign sel1      = sel_q[2];
    assign sel2      = sel_q[1];
    assign sel3      = sel_q[0];
    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mux8_rr_scheduler
//
// Directed bench for mux8_rr_scheduler with SLOT_LEN=4 and IDLE_SEL=0.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, after the edge has settled.
// ---------------------------------------------------------------------------
module tb_mux8_rr_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       lock;
    logic       sel1, sel2, sel3;
    logic [7:0] gnt;
    logic       gnt_valid;

    int tests;
    int fails;

    mux8_rr_scheduler #(
        .SLOT_LEN (4),
        .IDLE_SEL (3'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef MUX_SCHED_LOCK_EN
        .lock      (lock),
`endif
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks gnt, sel and gnt_valid for an expected owner; owner<0 means idle.
    task automatic check_owner(input string tag, input int owner);
        logic [7:0] eg;
        logic [7:0] es;
        logic [7:0] ev;
        if (owner < 0) begin
            eg = 8'h00;
            es = 8'h00;
            ev = 8'h00;
        end else begin
            eg = 8'h01 << owner;
            es = 8'(owner);
            ev = 8'h01;
        end
        check({tag, ".gnt"}, gnt, eg);
        check({tag, ".sel"}, {5'd0, sel1, sel2, sel3}, es);
        check({tag, ".vld"}, {7'd0, gnt_valid}, ev);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        req   = 8'hFF;
        lock  = 1'b0;

        // 1: reset held for two cycles with all requests high
        tick();
        check_owner("rst_c1", -1);
        tick();
        check_owner("rst_c2", -1);

        // 2: full request set; grants run 0..7 then back to 0, 4 cycles each
        rst = 1'b0;
        for (int n = 0; n < 36; n++) begin
            tick();
            check_owner($sformatf("rr_n%0d", n), (n / 4) % 8);
        end

        // 3: a single requester is re-granted at every expiry
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h01;
        for (int n = 0; n < 12; n++) begin
            tick();
            check_owner($sformatf("solo_n%0d", n), 0);
        end

        // 4: owner 2 drops its request early, so 7 wins; then everything drops and the block goes idle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h04;
        tick();
        check_owner("early_own2", 2);
        req = 8'h81;
        tick();
        check_owner("early_to7", 7);
        req = 8'h00;
        tick();
        check_owner("early_idle", -1);
        tick();
        check_owner("idle_stays", -1);

        // A new request mid-slot does not pre-empt; it wins at expiry after wrapping past 7
        req = 8'h02;
        tick();
        check_owner("nopre_own1", 1);
        req = 8'h03;
        for (int n = 0; n < 3; n++) begin
            tick();
            check_owner($sformatf("nopre_hold%0d", n), 1);
        end
        tick();
        check_owner("nopre_to0", 0);

        // 5: reset in the middle of a slot, then restart from requester 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h10;
        tick();
        check_owner("mid_own4", 4);
        req = 8'hFF;
        rst = 1'b1;
        tick();
        check_owner("mid_rst", -1);
        rst = 1'b0;
        tick();
        check_owner("post_rst0", 0);

`ifdef MUX_SCHED_LOCK_EN
        // 6: lock holds owner 5 for as long as lock stays high; the slot then finishes its remaining 3 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h20;
        tick();
        check_owner("lock_own5", 5);
        req  = 8'hFF;
        lock = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            check_owner($sformatf("lock_n%0d", n), 5);
        end
        lock = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check_owner($sformatf("unlock_n%0d", n), 5);
        end
        tick();
        check_owner("unlock_to6", 6);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
